// File: rtl/layernorm_hls_dl_pkg.sv
// Shared types and helpers for the LayerNorm dataflow deadlock-report controller.
//   dl_state_t        : controller FSM states
//   pid_w(n)          : index width for n processes (never less than 1)
//   DEF_TRACE_TIMEOUT : default TRACE cycle budget when the timeout build is enabled
//   TRACE_CNT_W       : width of the saturating TRACE cycle counter
package layernorm_hls_dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONFIRM,
    ORIGIN,
    TRACE,
    DONE
  } dl_state_t;

  localparam int DEF_TRACE_TIMEOUT = 64;
  localparam int TRACE_CNT_W       = 16;

  function automatic int pid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layernorm_hls_dl_prio_enc.sv
// Lowest-set-bit priority encoder.
//   req   in  N   request vector
//   idx   out W   index of the lowest set bit (0 when none set)
//   valid out 1   at least one bit of req is set
module layernorm_hls_dl_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layernorm_hls_deadlock_report_ctrl.sv
// Central end of the HLS deadlock-detection ring for the LayerNorm dataflow region.
// Debounces per-process detect bits, launches a trace token from the lowest
// detecting process, accumulates which processes held the token, and latches a
// sticky report when the token returns to its origin.
//
// Optional build macro: LAYERNORM_DL_TRACE_TIMEOUT_EN
//   defined   : a saturating counter forces a report after TRACE_TIMEOUT TRACE cycles
//   undefined : TRACE waits indefinitely, trace_timeout is tied 0
//
// Ports
//   clock            in  1         rising-edge clock
//   reset            in  1         asynchronous, active-low
//   dl_detect_vec    in  PROC_NUM  per-process dl_detect_out
//   token_active_vec in  PROC_NUM  per-process token presence
//   dl_detect_in     out 1         broadcast, sticky once tracing starts
//   origin_vec       out PROC_NUM  one-hot, one-cycle origin pulse
//   token_clear      out 1         combinational pulse on token return (or timeout)
//   deadlock_found   out 1         sticky report valid
//   deadlock_pid     out PID_W     origin process of the reported cycle
//   cycle_mask       out PROC_NUM  processes seen holding the token
//   trace_timeout    out 1         sticky, report came from the timeout
module layernorm_hls_deadlock_report_ctrl
  import layernorm_hls_dl_pkg::*;
#(
  parameter  int PROC_NUM      = 4,
  parameter  int DEBOUNCE      = 2,
  parameter  int TRACE_TIMEOUT = DEF_TRACE_TIMEOUT,
  localparam int PID_W         = pid_w(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_active_vec,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                deadlock_found,
  output logic [PID_W-1:0]    deadlock_pid,
  output logic [PROC_NUM-1:0] cycle_mask,
  output logic                trace_timeout
);

  localparam int DBC_W = pid_w(DEBOUNCE + 1);

  if (DEBOUNCE < 1 || TRACE_TIMEOUT < 1) begin : g_bad_params
    $error("DEBOUNCE and TRACE_TIMEOUT must both be at least 1");
  end

  dl_state_t           state_q, state_d;
  logic [PID_W-1:0]    cand_q;
  logic [DBC_W-1:0]    dbc_q;
  logic [PROC_NUM-1:0] origin_vec_q;
  logic                dl_detect_in_q;
  logic [PROC_NUM-1:0] cycle_mask_q;
  logic                found_q;
  logic [PID_W-1:0]    pid_q;

  logic [PID_W-1:0]    enc_idx;
  logic                enc_valid;
  logic                cand_hit;
  logic [PROC_NUM-1:0] cand_onehot;
  logic                trace_expired;
  logic                timeout_fire;

  layernorm_hls_dl_prio_enc #(
    .N (PROC_NUM),
    .W (PID_W)
  ) u_prio_enc (
    .req   (dl_detect_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // The candidate's own detect bit doubles as the token-return indication.
  assign cand_hit    = dl_detect_vec[cand_q];
  assign cand_onehot = PROC_NUM'(1) << cand_q;

`ifdef LAYERNORM_DL_TRACE_TIMEOUT_EN
  logic [TRACE_CNT_W-1:0] trace_cnt_q;
  logic                   timeout_q;

  // Counts TRACE cycles already spent; saturates rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_cnt_q <= '0;
    end else if (state_q != TRACE) begin
      trace_cnt_q <= '0;
    end else if (trace_cnt_q != '1) begin
      trace_cnt_q <= trace_cnt_q + 1'b1;
    end
  end

  // Fires in the TRACE_TIMEOUT-th TRACE cycle without a return.
  assign trace_expired = (trace_cnt_q == TRACE_CNT_W'(TRACE_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (state_q == TRACE && state_d == DONE) begin
      timeout_q <= timeout_fire;
    end
  end

  assign trace_timeout = timeout_q;
`else
  assign trace_expired = 1'b0;
  assign trace_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    token_clear  = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE:    if (enc_valid) state_d = CONFIRM;
      CONFIRM: begin
        if (!cand_hit) begin
          state_d = IDLE;
        end else if (dbc_q == DBC_W'(DEBOUNCE)) begin
          state_d = ORIGIN;
        end
      end
      ORIGIN:  state_d = TRACE;
      TRACE: begin
        // A genuine return takes priority over a coincident timeout.
        if (cand_hit) begin
          token_clear = 1'b1;
          state_d     = DONE;
        end else if (trace_expired) begin
          token_clear  = 1'b1;
          timeout_fire = 1'b1;
          state_d      = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cand_q         <= '0;
      dbc_q          <= '0;
      origin_vec_q   <= '0;
      dl_detect_in_q <= 1'b0;
      cycle_mask_q   <= '0;
      found_q        <= 1'b0;
      pid_q          <= '0;
    end else begin
      state_q      <= state_d;
      origin_vec_q <= '0;

      if (state_q == IDLE && enc_valid) begin
        cand_q <= enc_idx;
        dbc_q  <= DBC_W'(1);
      end

      if (state_q == CONFIRM && cand_hit && dbc_q != DBC_W'(DEBOUNCE)) begin
        dbc_q <= dbc_q + 1'b1;
      end

      // Origin outputs are registered on entry so they appear with ORIGIN.
      if (state_q == CONFIRM && state_d == ORIGIN) begin
        dl_detect_in_q <= 1'b1;
        origin_vec_q   <= cand_onehot;
        cycle_mask_q   <= cand_onehot;
      end

      if (state_q == TRACE) begin
        cycle_mask_q <= cycle_mask_q | token_active_vec;
      end

      if (state_q == TRACE && state_d == DONE) begin
        found_q <= 1'b1;
        pid_q   <= cand_q;
      end
    end
  end

  assign dl_detect_in   = dl_detect_in_q;
  assign origin_vec     = origin_vec_q;
  assign deadlock_found = found_q;
  assign deadlock_pid   = pid_q;
  assign cycle_mask     = cycle_mask_q;

endmodule

// File: tb/tb_layernorm_hls_deadlock_report_ctrl.sv
// Scoreboard bench for layernorm_hls_deadlock_report_ctrl (PROC_NUM=4,
// DEBOUNCE=2, TRACE_TIMEOUT=16). Stimulus pushes expected events (origin pulse,
// token_clear, report) with their cycle numbers; a negedge monitor pops and
// compares whenever the DUT presents one. Honours LAYERNORM_DL_TRACE_TIMEOUT_EN.
module tb_layernorm_hls_deadlock_report_ctrl;

  typedef enum int {EV_ORIGIN, EV_CLEAR, EV_REPORT} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [3:0] vec;
    logic [1:0] pid;
    logic       timeout;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dl_detect_vec = '0;
  logic [3:0] token_active_vec = '0;
  logic       dl_detect_in;
  logic [3:0] origin_vec;
  logic       token_clear;
  logic       deadlock_found;
  logic [1:0] deadlock_pid;
  logic [3:0] cycle_mask;
  logic       trace_timeout;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  logic prev_found = 1'b0;

  layernorm_hls_deadlock_report_ctrl #(
    .PROC_NUM      (4),
    .DEBOUNCE      (2),
    .TRACE_TIMEOUT (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dl_detect_vec    (dl_detect_vec),
    .token_active_vec (token_active_vec),
    .dl_detect_in     (dl_detect_in),
    .origin_vec       (origin_vec),
    .token_clear      (token_clear),
    .deadlock_found   (deadlock_found),
    .deadlock_pid     (deadlock_pid),
    .cycle_mask       (cycle_mask),
    .trace_timeout    (trace_timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string ev_name(input ev_kind_t k);
    case (k)
      EV_ORIGIN: return "origin";
      EV_CLEAR:  return "token_clear";
      default:   return "report";
    endcase
  endfunction

  task automatic push_ev(input ev_kind_t k, input int c, input logic [3:0] v,
                         input logic [1:0] p, input logic t);
    ev_t e;
    e.kind = k; e.cyc = c; e.vec = v; e.pid = p; e.timeout = t;
    exp_q.push_back(e);
  endtask

  task automatic handle(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event expected none (cycle %0d)", ev_name(k), cyc);
      return;
    end
    e = exp_q.pop_front();
    check({ev_name(e.kind), "_kind"}, 32'(k), 32'(e.kind));
    check({ev_name(e.kind), "_cycle"}, 32'(cyc), 32'(e.cyc));
    case (k)
      EV_ORIGIN: begin
        check("origin_vec", 32'(origin_vec), 32'(e.vec));
        check("origin_dl_detect_in", 32'(dl_detect_in), 32'd1);
      end
      EV_REPORT: begin
        check("report_pid", 32'(deadlock_pid), 32'(e.pid));
        check("report_mask", 32'(cycle_mask), 32'(e.vec));
        check("report_timeout", 32'(trace_timeout), 32'(e.timeout));
      end
      default: ;
    endcase
  endtask

  // Monitor: outputs are stable half a cycle after the inputs change.
  always @(negedge clock) begin
    if (origin_vec != '0) handle(EV_ORIGIN);
    if (token_clear) handle(EV_CLEAR);
    if (deadlock_found && !prev_found) handle(EV_REPORT);
    prev_found = deadlock_found;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dl_detect_vec = '0;
    token_active_vec = '0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dl_detect_in"}, 32'(dl_detect_in), 32'd0);
    check({tag, "_origin_vec"}, 32'(origin_vec), 32'd0);
    check({tag, "_token_clear"}, 32'(token_clear), 32'd0);
    check({tag, "_deadlock_found"}, 32'(deadlock_found), 32'd0);
    check({tag, "_deadlock_pid"}, 32'(deadlock_pid), 32'd0);
    check({tag, "_cycle_mask"}, 32'(cycle_mask), 32'd0);
    check({tag, "_trace_timeout"}, 32'(trace_timeout), 32'd0);
  endtask

  // Hold detect until the origin pulse is due (DEBOUNCE+1 = 3 cycles after rise).
  task automatic launch(input logic [3:0] vec, input logic [1:0] cand);
    push_ev(EV_ORIGIN, cyc + 3, 4'b0001 << cand, 2'd0, 1'b0);
    dl_detect_vec = vec;
    step(3);
    dl_detect_vec = '0;
    token_active_vec = '0;
  endtask

  // Origin 2, token walks 2 -> 3 -> 1, then origin reports its return.
  task automatic full_trace();
    launch(4'b0100, 2'd2);
    token_active_vec = 4'b0100;
    step(1);
    token_active_vec = 4'b1000;
    step(1);
    token_active_vec = 4'b0010;
    step(1);
    token_active_vec = 4'b0000;
    dl_detect_vec = 4'b0100;
    push_ev(EV_CLEAR, cyc, 4'b0000, 2'd0, 1'b0);
    push_ev(EV_REPORT, cyc + 1, 4'b1110, 2'd2, 1'b0);
    step(1);
    dl_detect_vec = '0;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check_all_zero("reset");
    step(2);
    reset = 1'b1;
    step(2);

    // Transient detect: one cycle only, never confirmed.
    dl_detect_vec = 4'b1010;
    step(1);
    dl_detect_vec = '0;
    step(6);
    check("transient_dl_detect_in", 32'(dl_detect_in), 32'd0);
    check("transient_found", 32'(deadlock_found), 32'd0);

    // Normal trace, then DONE must hold against further activity.
    full_trace();
    dl_detect_vec = 4'b1111;
    token_active_vec = 4'b1111;
    step(5);
    check("done_found", 32'(deadlock_found), 32'd1);
    check("done_pid", 32'(deadlock_pid), 32'd2);
    check("done_mask", 32'(cycle_mask), 32'hE);
    check("done_dl_detect_in", 32'(dl_detect_in), 32'd1);
    check("done_token_clear", 32'(token_clear), 32'd0);
    dl_detect_vec = '0;
    token_active_vec = '0;

    // Simultaneous bits pick the lowest; a non-origin bit in TRACE is ignored.
    do_reset();
    launch(4'b1001, 2'd0);
    begin
      int o;
      o = cyc;
      step(1);
      dl_detect_vec = 4'b1000;
      token_active_vec = 4'b1000;
`ifdef LAYERNORM_DL_TRACE_TIMEOUT_EN
      push_ev(EV_CLEAR, o + 16, 4'b0000, 2'd0, 1'b0);
      push_ev(EV_REPORT, o + 17, 4'b1001, 2'd0, 1'b1);
`endif
      step(3);
      dl_detect_vec = '0;
      token_active_vec = '0;
    end
`ifdef LAYERNORM_DL_TRACE_TIMEOUT_EN
    step(20);
    check("timeout_flag", 32'(trace_timeout), 32'd1);
    check("timeout_found", 32'(deadlock_found), 32'd1);
`else
    step(100);
    check("no_timeout_found", 32'(deadlock_found), 32'd0);
    check("no_timeout_dl_detect_in", 32'(dl_detect_in), 32'd1);
    check("no_timeout_flag", 32'(trace_timeout), 32'd0);
`endif

    // Asynchronous reset in the middle of a trace, then a clean rerun.
    do_reset();
    launch(4'b0100, 2'd2);
    token_active_vec = 4'b1000;
    step(3);
    reset = 1'b0;
    #1;
    check_all_zero("midtrace_reset");
    token_active_vec = '0;
    step(2);
    reset = 1'b1;
    step(1);
    full_trace();
    step(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
